// File: rtl/sr_to_t_flip_flop.sv
// T flip-flop array: each bit is an SR flip-flop driven by T-to-SR conversion,
// so every rising clk gives Q_next = Q ^ T. Asynchronous active-low reset.

module sr_to_t_bit #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);
    logic s;
    logic r;

    // S/R can never both be high here; the core still defines that case as hold.
    assign s = t & ~q;
    assign r = t & q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VAL;
        end else begin
            unique case ({s, r})
                2'b10:   q <= 1'b1;
                2'b01:   q <= 1'b0;
                default: q <= q;
            endcase
        end
    end
endmodule

module sr_to_t_flip_flop #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] T,
    output logic [WIDTH-1:0] Q
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sr_to_t_bit #(
            .RESET_VAL (RESET_VAL[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .t     (T[i]),
            .q     (Q[i])
        );
    end
endmodule

// File: tb/tb_sr_to_t_flip_flop.sv
// Scoreboard bench for sr_to_t_flip_flop: a 1-bit and a 4-bit (reset 4'b1010)
// instance share clock and reset; expectations are queued, a monitor checks them.

module tb_sr_to_t_flip_flop;
    logic       clk;
    logic       reset;
    logic       T1;
    logic [3:0] T4;
    logic       Q1;
    logic [3:0] Q4;

    localparam logic [3:0] RV4 = 4'b1010;

    sr_to_t_flip_flop u_dut1 (
        .clk   (clk),
        .reset (reset),
        .T     (T1),
        .Q     (Q1)
    );

    sr_to_t_flip_flop #(.WIDTH(4), .RESET_VAL(RV4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .T     (T4),
        .Q     (Q4)
    );

    typedef struct {
        logic       q1;
        logic [3:0] q4;
        string      name;
    } exp_t;

    exp_t sb[$];
    event async_ev;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: Q is registered, so each posedge (or async reset) produces one
    // observable result; check it 1 time unit later against the queue head.
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk or async_ev);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if (Q1 !== e.q1 || Q4 !== e.q4) begin
                    n_bad++;
                    $display("FAIL %s: got Q1=%b Q4=%b, expected Q1=%b Q4=%b",
                             e.name, Q1, Q4, e.q1, e.q4);
                end
            end
        end
    end

    // Drive one cycle of stimulus at negedge and queue the post-edge expectation.
    task automatic step(input logic rst, input logic t1, input logic [3:0] t4,
                        input logic e1, input logic [3:0] e4, input string nm,
                        input bit glitch);
        @(negedge clk);
        reset = rst;
        T1    = t1;
        T4    = t4;
        sb.push_back('{e1, e4, nm});
        if (glitch) begin
            #2;
            T1 = ~t1;
            T4 = ~t4;
            #1;
            T1 = t1;
            T4 = t4;
        end
    endtask

    initial begin
        logic       m1;
        logic [3:0] m4;
        logic       r1;
        logic [3:0] r4;
        bit         rst_cyc;
        bit         gl;

        reset = 1'b1;
        T1    = 1'b1;
        T4    = 4'b1111;
        #1;
        reset = 1'b0;
        sb.push_back('{1'b0, RV4, "reset_async_assert"});
        -> async_ev;

        // In reset with T=1: no toggling.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 4'b1111, 1'b0, RV4, "in_reset_hold", 1'b0);

        // Release; T=0 for 2 edges.
        step(1'b1, 1'b0, 4'b0000, 1'b0, RV4, "release_t0_a", 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0, RV4, "release_t0_b", 1'b0);

        // Toggle twice; the 4-bit lane shows independent per-bit toggles.
        step(1'b1, 1'b1, 4'b0110, 1'b1, 4'b1100, "toggle_1", 1'b0);
        step(1'b1, 1'b1, 4'b1111, 1'b0, 4'b0011, "toggle_2", 1'b0);

        // Hold then toggle.
        step(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0011, "hold_0", 1'b0);
        step(1'b1, 1'b1, 4'b0000, 1'b1, 4'b0011, "toggle_after_hold", 1'b0);
        step(1'b1, 1'b1, 4'b0000, 1'b0, 4'b0011, "back_to_0", 1'b0);

        // Continuous T=1: divide-by-2.
        for (int i = 0; i < 6; i++)
            step(1'b1, 1'b1, 4'b0000, (i % 2 == 0), 4'b0011, "divide_by_2", 1'b0);
        step(1'b1, 1'b1, 4'b0000, 1'b1, 4'b0011, "q_high_before_reset", 1'b0);

        // Mid-cycle reset with Q1=1 must clear immediately.
        @(posedge clk);
        #3;
        reset = 1'b0;
        sb.push_back('{1'b0, RV4, "reset_mid_cycle"});
        -> async_ev;

        // Randomized phase against a Q ^= T model, with occasional resets
        // and T glitches between edges.
        m1 = 1'b0;
        m4 = RV4;
        for (int i = 0; i < 300; i++) begin
            rst_cyc = ($urandom_range(0, 19) == 0);
            r1      = 1'($urandom);
            r4      = 4'($urandom);
            gl      = 1'($urandom);
            if (rst_cyc) begin
                m1 = 1'b0;
                m4 = RV4;
            end else begin
                m1 = m1 ^ r1;
                m4 = m4 ^ r4;
            end
            step(!rst_cyc, r1, r4, m1, m4, "random", gl);
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        done = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
